ibex_instr_mem_responder: RTL

Memory-side responder for the core's instruction fetch interface (req/gnt/rvalid/rdata/err). It sits between the IF stage's instruction port and a single-port, 1-cycle-latency instruction SRAM. It grants requests subject to an outstanding-request limit and a stall input, and returns in-order responses at a fixed configurable latency. Out-of-range and misaligned fetches are flagged as bus errors. It is used as the instruction-side slave in simple system and FPGA integrations.

---
 rtl/ibex_instr_mem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder: grants req/gnt fetches into a 1-cycle SRAM and returns in-order
// responses at a fixed latency. Optional error injection via IBEX_INSTR_RESP_ERR_INJECT_EN.
module ibex_instr_mem_responder #(
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned MemWords       = 4096,
  parameter int unsigned RespLatency    = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  input  logic                        stall_i,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        busy_o
`ifdef IBEX_INSTR_RESP_ERR_INJECT_EN
  ,
  input  logic                        err_inject_i
`endif
);

  localparam int unsigned AW = $clog2(MemWords);
  localparam int unsigned L  = RespLatency;
  // 33-bit bounds so a window ending at the top of the address space cannot wrap
  localparam logic [32:0] BaseExt  = {1'b0, BaseAddr};
  localparam logic [32:0] LimitExt = BaseExt + (33'(MemWords) << 2);

  logic [2:0]    outstanding_q, outstanding_d;
  logic [L-1:0]  valid_q, err_q;
  logic [31:0]   stage_data [L];
  logic [32:0]   addr_ext;
  logic [31:0]   offset;
  logic          in_range, aligned, inject, hit, gnt, rvalid;

`ifdef IBEX_INSTR_RESP_ERR_INJECT_EN
  assign inject = err_inject_i;
`else
  assign inject = 1'b0;
`endif

  assign addr_ext = {1'b0, instr_addr_i};
  assign in_range = (addr_ext >= BaseExt) && (addr_ext < LimitExt);
  assign aligned  = (instr_addr_i[1:0] == 2'b00);
  assign hit      = aligned & in_range & ~inject;

  assign gnt    = instr_req_i & ~stall_i & ~rst_i & (outstanding_q < 3'(MaxOutstanding));
  assign rvalid = valid_q[L-1];

  assign offset     = instr_addr_i - BaseAddr;
  assign mem_addr_o = AW'(offset >> 2);
  assign mem_req_o  = gnt & hit;

  // Stage 1 data is the SRAM output itself, valid the cycle after the read
  assign stage_data[0] = (valid_q[0] & ~err_q[0]) ? mem_rdata_i : 32'h0;

  if (L > 1) begin : g_data
    logic [31:0] data_q [L-1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < int'(L) - 1; i++) data_q[i] <= 32'h0;
      end else begin
        for (int i = 0; i < int'(L) - 1; i++) data_q[i] <= stage_data[i];
      end
    end

    for (genvar k = 1; k < L; k++) begin : g_tap
      assign stage_data[k] = data_q[k-1];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q + 3'(gnt) - 3'(rvalid);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      err_q         <= '0;
      outstanding_q <= 3'd0;
    end else begin
      valid_q[0] <= gnt;
      err_q[0]   <= gnt & ~hit;
      for (int i = 1; i < int'(L); i++) begin
        valid_q[i] <= valid_q[i-1];
        err_q[i]   <= err_q[i-1];
      end
      outstanding_q <= outstanding_d;
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_err_o    = rvalid & err_q[L-1];
  assign instr_rdata_o  = rvalid ? stage_data[L-1] : 32'h0;
  assign busy_o         = (outstanding_q != 3'd0);

endmodule
